// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and writeback entry type; FDIV_WB_DZ_EN adds the dz bit
package fpu_pkg;

  localparam int FDIV_LAT  = 3;
  localparam int FDIV_TAGW = 5;

  typedef struct packed {
    logic [FDIV_TAGW-1:0] tag;
    logic [31:0]          data;
`ifdef FDIV_WB_DZ_EN
    logic                 dz;
`endif
  } fdiv_wb_entry_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - parameterised synchronous FIFO with occupancy count
module fpu_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so the outputs are clean out of reset.
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wrap_inc(wptr);
      if (do_pop)  rptr <= wrap_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/fdiv_wb_queue.sv
// rtl/fdiv_wb_queue.sv - fdiv writeback queue: tag tracking pipe, credit issue control, result FIFO
// Optional FDIV_WB_DZ_EN carries a zero/denormal-divisor flag alongside each tag.
module fdiv_wb_queue
  import fpu_pkg::*;
#(
  parameter int LAT   = FDIV_LAT,
  parameter int DEPTH = 4,
  parameter int TAGW  = FDIV_TAGW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  input  logic [TAGW-1:0] issue_tag,
`ifdef FDIV_WB_DZ_EN
  input  logic [7:0]      issue_x2_exp,
  output logic            wb_dz,
`endif
  output logic            issue_ready,
  input  logic [31:0]     fdiv_y,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [TAGW-1:0] wb_tag,
  output logic [31:0]     wb_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic            issue_fire, push, fifo_empty;
  logic [CW-1:0]   fifo_count, inflight;
  logic [LAT-1:0]  pipe_v;
  logic [TAGW-1:0] pipe_tag [LAT];
  fdiv_wb_entry_t  push_entry, head_entry;

  assign issue_fire  = issue_valid && issue_ready;
  assign push        = pipe_v[LAT-1];
  // Every issued division holds a FIFO slot from issue until it is popped.
  assign issue_ready = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_v   <= '0;
      inflight <= '0;
    end else begin
      pipe_v[0] <= issue_fire;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
      case ({issue_fire, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= issue_tag;
    for (int i = 1; i < LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

`ifdef FDIV_WB_DZ_EN
  logic [LAT-1:0] pipe_dz;

  always_ff @(posedge clk) begin
    pipe_dz[0] <= (issue_x2_exp == 8'h00);
    for (int i = 1; i < LAT; i++) pipe_dz[i] <= pipe_dz[i-1];
  end

  assign push_entry.dz = pipe_dz[LAT-1];
  assign wb_dz         = head_entry.dz;
`endif

  assign push_entry.tag  = pipe_tag[LAT-1];
  assign push_entry.data = fdiv_y;

  fpu_sync_fifo #(
    .W     ($bits(fdiv_wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_entry),
    .pop       (wb_ready),
    .head      (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wb_valid = !fifo_empty;
  assign wb_tag   = head_entry.tag;
  assign wb_data  = head_entry.data;

endmodule

// File: tb/tb_fdiv_wb_queue.sv
// tb/tb_fdiv_wb_queue.sv - directed bench for fdiv_wb_queue with a 3-cycle fdiv result model
module tb_fdiv_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_tag = '0;
  logic        issue_ready;
  logic [31:0] fdiv_y;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
`ifdef FDIV_WB_DZ_EN
  logic [7:0]  issue_x2_exp = 8'h7f;
  logic        wb_dz;
`endif

  logic [31:0] op = '0, p1 = '0, p2 = '0, p3 = '0;
  int          total = 0;
  int          bad = 0;
  logic [4:0]  expq [$];
  int          nxt, got, first_wb, ncyc;

  always #5 clk = ~clk;

  // fdiv stand-in: whatever result is presented in cycle c appears on fdiv_y in cycle c+3.
  always @(posedge clk) begin
    p1 <= op;
    p2 <= p1;
    p3 <= p2;
  end
  assign fdiv_y = p3;

  fdiv_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .issue_valid  (issue_valid),
    .issue_tag    (issue_tag),
`ifdef FDIV_WB_DZ_EN
    .issue_x2_exp (issue_x2_exp),
    .wb_dz        (wb_dz),
`endif
    .issue_ready  (issue_ready),
    .fdiv_y       (fdiv_y),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    issue_valid = 1'b0;
    wb_ready = 1'b0;
    op = '0;
    repeat (2) cyc();
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn && dut.push)
      chk("push_while_full", (dut.fifo_count < DEPTH) ? 32'd1 : 32'd0, 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // single issue
    do_reset();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_issue_ready", issue_ready, 1);
`ifdef FDIV_WB_DZ_EN
    chk("rst_wb_dz", wb_dz, 0);
`endif
    issue_valid = 1'b1; issue_tag = 5'd5; op = 32'h4000_0000; wb_ready = 1'b1;
    cyc();
    issue_valid = 1'b0; op = 32'hdead_beef;
    chk("single_c1_valid", wb_valid, 0);
    cyc();
    chk("single_c2_valid", wb_valid, 0);
    cyc();
    chk("single_c3_valid", wb_valid, 0);
    cyc();
    chk("single_c4_valid", wb_valid, 1);
    chk("single_c4_tag", wb_tag, 5);
    chk("single_c4_data", wb_data, 32'h4000_0000);
    cyc();
    chk("single_c5_valid", wb_valid, 0);

    // backpressure
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready_open", issue_ready, 1);
      issue_valid = 1'b1; issue_tag = 5'(i + 1); op = 32'h3f80_0000 + 32'(i + 1);
      cyc();
    end
    issue_valid = 1'b0; op = 32'hdead_beef;
    chk("bp_ready_drop_c4", issue_ready, 0);
    cyc();
    chk("bp_hold_valid_c5", wb_valid, 1);
    chk("bp_hold_tag_c5", wb_tag, 1);
    cyc();
    cyc();
    chk("bp_ready_c7", issue_ready, 0);
    chk("bp_hold_tag_c7", wb_tag, 1);
    chk("bp_hold_data_c7", wb_data, 32'h3f80_0001);
    wb_ready = 1'b1;
    cyc();
    chk("bp_ready_after_pop", issue_ready, 1);
    for (int k = 2; k <= 4; k++) begin
      chk("bp_order_valid", wb_valid, 1);
      chk("bp_order_tag", wb_tag, k);
      chk("bp_order_data", wb_data, 32'h3f80_0000 + 32'(k));
      cyc();
    end
    chk("bp_drained", wb_valid, 0);

    // simultaneous push and pop at count DEPTH-1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_tag = 5'(10 + i); op = 32'h4040_0000 + 32'(10 + i);
      cyc();
    end
    issue_valid = 1'b0; op = '0;
    cyc();
    cyc();
    chk("pp_count_before", 32'(dut.fifo_count), DEPTH - 1);
    chk("pp_tag_c6", wb_tag, 10);
    wb_ready = 1'b1;
    cyc();
    chk("pp_count_after", 32'(dut.fifo_count), DEPTH - 1);
    for (int k = 11; k <= 13; k++) begin
      chk("pp_order_tag", wb_tag, k);
      chk("pp_order_data", wb_data, 32'h4040_0000 + 32'(k));
      cyc();
    end
    chk("pp_drained", wb_valid, 0);

    // sustained issue with a ready consumer
    do_reset();
    wb_ready = 1'b1;
    nxt = 0; got = 0; first_wb = -1;
    for (ncyc = 0; ncyc < 200 && got < 20; ncyc++) begin
      if (wb_valid) begin
        if (first_wb < 0) first_wb = ncyc;
        if (expq.size() == 0) begin
          chk("tp_spurious_wb", 1, 0);
        end else begin
          chk("tp_tag", wb_tag, expq[0]);
          chk("tp_data", wb_data, 32'h4100_0000 + 32'(expq[0]));
          void'(expq.pop_front());
        end
        got++;
      end
      if (nxt < 20 && issue_ready) begin
        issue_valid = 1'b1; issue_tag = 5'(nxt); op = 32'h4100_0000 + 32'(nxt);
        expq.push_back(5'(nxt));
        nxt++;
      end else begin
        issue_valid = 1'b0; op = 32'hbad0_0000;
      end
      cyc();
    end
    issue_valid = 1'b0;
    chk("tp_issued", nxt, 20);
    chk("tp_received", got, 20);
    chk("tp_first_latency", first_wb, 4);

    // reset in flight
    do_reset();
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_tag = 5'd7; op = 32'h1111_0000;
    cyc();
    issue_tag = 5'd8; op = 32'h2222_0000;
    cyc();
    issue_valid = 1'b0; op = '0;
    rstn = 1'b0;
    #1;
    chk("mr_async_ready", issue_ready, 1);
    cyc();
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("mr_wb_valid", wb_valid, 0);
      chk("mr_issue_ready", issue_ready, 1);
      cyc();
    end

`ifdef FDIV_WB_DZ_EN
    // divisor flag
    do_reset();
    issue_valid = 1'b1; issue_tag = 5'd3; issue_x2_exp = 8'h00; op = 32'h3f80_0000;
    cyc();
    issue_tag = 5'd4; issue_x2_exp = 8'h80; op = 32'h4080_0000;
    cyc();
    issue_valid = 1'b0; issue_x2_exp = 8'h7f; op = '0;
    cyc();
    cyc();
    chk("dz_first_tag", wb_tag, 3);
    chk("dz_first_flag", wb_dz, 1);
    wb_ready = 1'b1;
    cyc();
    chk("dz_second_tag", wb_tag, 4);
    chk("dz_second_flag", wb_dz, 0);
    cyc();
    chk("dz_drained", wb_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
